// File: rtl/cfg_uart_pkg.sv
// Shared constants for the configuration UART transmitter.
package cfg_uart_pkg;

  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Serializer state encoding.
  typedef logic [1:0] uart_state_t;
  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/cfg_byte_fifo.sv
// Small synchronous byte FIFO buffering bytes ahead of the UART serializer.
module cfg_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; reset discards all buffered bytes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  // Storage array, written only on an accepted push outside reset.
  always_ff @(posedge CLK) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cfg_uart_tx.sv
// 8N1 UART transmitter feeding fabric configuration bytes, with a byte FIFO.
module cfg_uart_tx
  import cfg_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        Tx,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  uart_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [15:0]   sent_q, sent_d;
  logic          pop_c;
  logic          bit_end_c;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;

  cfg_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK         (CLK),
    .reset       (reset),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (pop_c),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bit_end_c  = (timer_q == TIMER_LAST);
  assign in_ready   = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign Tx         = tx_q;
  assign bytes_sent = sent_q;

  // Next-state, serializer and pop decision.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    sent_d    = sent_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_data;
          tx_d    = 1'b0;
          timer_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          timer_d = '0;
          sent_d  = sent_q + 16'd1;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_data;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight and idles the line.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      sent_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      sent_q    <= sent_d;
    end
  end

endmodule

// File: tb/tb_cfg_uart_tx.sv
// Bench for cfg_uart_tx: frame-level model, mid-bit receiver, directed and random traffic.
module tb_cfg_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        Tx;
  logic        busy;
  logic [15:0] bytes_sent;

  always #5 CLK = ~CLK;

  cfg_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Tx         (Tx),
    .busy       (busy),
    .bytes_sent (bytes_sent)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: pending-byte queue plus position inside the current frame.
  logic [7:0]  m_q[$];
  logic [7:0]  exp_rx[$];
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [7:0]  m_cur = 8'd0;
  logic [15:0] m_sent = 16'd0;

  function automatic logic model_tx();
    int bitno;
    if (!m_active) return 1'b1;
    bitno = m_t / CPB;
    if (bitno == 0) return 1'b0;
    if (bitno <= 8) return m_cur[bitno-1];
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    bit         acc;
    logic [7:0] accb;
    if (reset) begin
      m_q.delete();
      exp_rx.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_sent   = 16'd0;
    end else begin
      acc  = in_valid && (m_q.size() < DEPTH);
      accb = in_data;
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          m_sent++;
          m_active = 1'b0;
        end else begin
          m_t++;
        end
      end
      if (!m_active && m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
        exp_rx.push_back(m_cur);
      end
      if (acc) m_q.push_back(accb);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("tx", 32'(Tx), 32'(model_tx()));
      chk("busy", 32'(busy), 32'(m_active || (m_q.size() > 0)));
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
      chk("bytes_sent", 32'(bytes_sent), 32'(m_sent));
    end
  end

  // Mid-bit sampling UART receiver.
  bit         rx_busy = 1'b0;
  int         rx_c = 0;
  logic [7:0] rx_b = 8'd0;
  logic [7:0] rx_last = 8'd0;
  int         rx_total = 0;
  bit         seen[256];
  int         busy_cycles = 0;

  always @(negedge CLK) begin
    logic [7:0] e;
    if (busy === 1'b1) busy_cycles++;
    if (reset || !chk_en) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (Tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_c    = 0;
      end
    end else begin
      rx_c++;
      if (rx_c == CPB / 2) begin
        chk("rx_start", 32'(Tx), 32'd0);
      end else if (rx_c == 9 * CPB + CPB / 2) begin
        chk("rx_stop", 32'(Tx), 32'd1);
        rx_busy = 1'b0;
        rx_total++;
        seen[rx_b] = 1'b1;
        rx_last = rx_b;
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got byte %0h expected none", rx_b);
        end else begin
          e = exp_rx.pop_front();
          if (rx_b !== e) begin
            errors++;
            $display("FAIL rx_byte: got %0h expected %0h", rx_b, e);
          end
        end
      end else if ((rx_c % CPB) == CPB / 2) begin
        rx_b[rx_c / CPB - 1] = Tx;
      end
    end
  end

  int stall_idx = -1;
  int put_idx = 0;

  // Present one byte and hold in_valid until it is taken; returns just after the accepting edge.
  task automatic put(input logic [7:0] b);
    bit rdy;
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge CLK);
      rdy = in_ready;
      if (!rdy && stall_idx < 0) stall_idx = put_idx;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 2000);
    if (!rdy) begin
      errors++;
      checks++;
      $display("FAIL put_timeout: byte %0h never accepted after %0d cycles", b, n);
    end
    put_idx++;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge CLK);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((m_active || m_q.size() > 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (m_active || m_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic random_gap();
    int k;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    k = $urandom_range(0, 5);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  int exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    int rx0;
    int nseen;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    chk_en = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    chk("reset_tx", 32'(Tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_bytes_sent", 32'(bytes_sent), 32'd0);

    // Single 0xA5 frame against a hand-written bit pattern.
    do_reset();
    put(8'hA5);
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge CLK);
    chk("a5_pre_start_tx", 32'(Tx), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      chk("a5_bit", 32'(Tx), 32'(exp_bits[i / 4]));
    end
    @(negedge CLK);
    chk("a5_busy_after", 32'(busy), 32'd0);
    chk("a5_bytes_sent", 32'(bytes_sent), 32'd1);
    chk("a5_rx_last", 32'(rx_last), 32'hA5);

    // Six bytes with in_valid held: back-pressure at four buffered, contiguous frames.
    do_reset();
    busy_cycles = 0;
    stall_idx   = -1;
    put_idx     = 0;
    for (int v = 0; v < 6; v++) put(8'(v));
    in_valid = 1'b0;
    wait_drain(2000);
    chk("six_stall_index", 32'(stall_idx), 32'd5);
    chk("six_busy_cycles", 32'(busy_cycles), 32'd241);
    chk("six_bytes_sent", 32'(bytes_sent), 32'd6);
    chk("six_rx_last", 32'(rx_last), 32'h05);

    // Reset ten cycles into a 0xFF frame with two bytes queued.
    do_reset();
    rx0 = rx_total;
    put(8'hFF);
    put(8'h11);
    put(8'h22);
    in_valid = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge CLK);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("abort_tx", 32'(Tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bytes_sent", 32'(bytes_sent), 32'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      chk("abort_idle_tx", 32'(Tx), 32'd1);
    end
    chk("abort_no_frames", 32'(rx_total - rx0), 32'd0);

    // in_data churn during a frame must not alter the byte on the line.
    do_reset();
    put(8'h3C);
    in_valid = 1'b0;
    for (int i = 0; i < 45; i++) begin
      in_data = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    wait_drain(2000);
    chk("latch_rx_last", 32'(rx_last), 32'h3C);

    // bytes_sent wrap from 0xFFFF.
    do_reset();
    @(posedge CLK);
    #2;
    force dut.sent_q = 16'hFFFF;
    m_sent = 16'hFFFF;
    #1;
    release dut.sent_q;
    @(negedge CLK);
    chk("wrap_preload", 32'(bytes_sent), 32'hFFFF);
    @(posedge CLK);
    #1;
    put(8'h5A);
    in_valid = 1'b0;
    wait_drain(2000);
    chk("wrap_bytes_sent", 32'(bytes_sent), 32'h0000);

    // All 256 byte values with random gaps, recovered by the receiver.
    do_reset();
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    rx0 = rx_total;
    for (int v = 0; v < 256; v++) begin
      put(8'(v));
      if ($urandom_range(0, 3) == 0) random_gap();
    end
    in_valid = 1'b0;
    wait_drain(20000);
    nseen = 0;
    for (int i = 0; i < 256; i++) nseen += int'(seen[i]);
    chk("all256_rx_count", 32'(rx_total - rx0), 32'd256);
    chk("all256_distinct", 32'(nseen), 32'd256);
    chk("all256_bytes_sent", 32'(bytes_sent), 32'd256);

    // Random values and random spacing.
    for (int n = 0; n < 150; n++) begin
      put(8'($urandom));
      if ($urandom_range(0, 1) == 0) random_gap();
    end
    in_valid = 1'b0;
    wait_drain(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_uart_tx.md
CFG_UART_TX -- requirements
Module: cfg_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, CLK cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries buffered ahead of the serializer; power of two, 2..16.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  configuration byte (bitstream byte) to send.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a byte this cycle.
REQ-008 SHALL have port Tx  output  1  UART serial line driving the fabric Rx config input; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress or buffer non-empty.
REQ-010 SHALL have port bytes_sent  output  16  count of completed frames.

Function
REQ-011 SHALL frame each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-012 SHALL accept a byte on a rising edge where in_valid && in_ready; in_ready = !full, from registered occupancy only (no same-cycle pop bypass when full).
REQ-013 SHALL keep accepted bytes in FIFO order; bytes never dropped, duplicated or reordered.
REQ-014 SHALL implement states IDLE, START, DATA, STOP: IDLE->START when FIFO non-empty (pop on that edge); START->DATA after CLKS_PER_BIT; DATA->STOP after 8th bit; STOP->START (FIFO non-empty, pop) or IDLE (empty).
REQ-015 SHALL register Tx; byte accepted at edge N into empty FIFO while IDLE -> Tx low from edge N+1.
REQ-016 SHALL emit back-to-back frames with no idle gap when the FIFO is non-empty at end of STOP.
REQ-017 SHALL drive busy = (state != IDLE) || FIFO non-empty, registered-state-derived, no combinational path from in_valid.
REQ-018 SHALL increment bytes_sent on the edge ending each stop bit; wraps 0xFFFF->0x0000.
REQ-019 SHALL ignore in_data changes during a frame (data latched into shift register at pop).
REQ-020 SHALL use a bit-timer counter of width $clog2(CLKS_PER_BIT) and a 3-bit data-bit index; no other dividers.

Reset
REQ-021 SHALL on reset: state IDLE, Tx=1, FIFO empty, in_ready=1, busy=0, bytes_sent=0, timers cleared.
REQ-022 SHALL on reset mid-frame abort the frame, force Tx=1 after that edge, discard buffered bytes; no partial frame resumes.
REQ-023 SHALL ignore in_valid during a reset cycle (no byte accepted).

Structure
REQ-024 SHALL place the state enum, frame-bit count (10) and default CLKS_PER_BIT in shared package cfg_uart_pkg.
REQ-025 SHALL implement the buffer as one sub-module cfg_byte_fifo (sync FIFO, push/pop/full/empty, same CLK/reset).
REQ-026 SHALL be usable in the fabric bench to drive the fabric configuration Rx from bitstream.hex bytes, replacing manual stimulus.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL check single byte 0xA5 -> Tx low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; bytes_sent=1; busy low after frame.
REQ-028 SHALL check 6 bytes 0x00..0x05 with in_valid held -> in_ready drops at 4 buffered; 6 contiguous 40-cycle frames, no gap, in order; bytes_sent=6.
REQ-029 SHALL check reset asserted 10 cycles into frame of 0xFF with 2 bytes queued -> Tx=1 next cycle, busy=0, bytes_sent=0, no further frames.
REQ-030 SHALL check in_data toggled mid-frame -> transmitted byte equals value at acceptance.
REQ-031 SHALL check bytes_sent preloaded via 65536 frames (or forced) -> wraps to 0x0000.
REQ-032 SHALL check a UART receiver model sampling mid-bit recovers all 256 byte values exactly.
